// File: rtl/branch_resolver_if.sv
// Bundles the branch resolver's fetch-side, s4-side and branch-table write signals.
// Optional statistics outputs exist only when BR_RESOLVER_STATS_EN is defined.
interface branch_resolver_if;
  logic        stall;
  logic        valid_s1;
  logic [31:0] inst_adress_s1;
  logic        p_s1;
  logic        hit_s1;
  logic [31:0] b_dest_out;
  logic        is_branch_s4;
  logic        taken_s4;
  logic [31:0] target_s4;
  logic        write_rp;
  logic        write_rt;
  logic        deviated_s4;
  logic [31:0] b_dest_in;
  logic [31:0] inst_adress_s4;
  logic        flush;
  logic [31:0] redirect_pc;
`ifdef BR_RESOLVER_STATS_EN
  logic [15:0] br_count;
  logic [15:0] mp_count;

  modport master (
    output stall, valid_s1, inst_adress_s1, p_s1, hit_s1, b_dest_out,
           is_branch_s4, taken_s4, target_s4,
    input  write_rp, write_rt, deviated_s4, b_dest_in, inst_adress_s4,
           flush, redirect_pc, br_count, mp_count
  );
  modport slave (
    input  stall, valid_s1, inst_adress_s1, p_s1, hit_s1, b_dest_out,
           is_branch_s4, taken_s4, target_s4,
    output write_rp, write_rt, deviated_s4, b_dest_in, inst_adress_s4,
           flush, redirect_pc, br_count, mp_count
  );
`else
  modport master (
    output stall, valid_s1, inst_adress_s1, p_s1, hit_s1, b_dest_out,
           is_branch_s4, taken_s4, target_s4,
    input  write_rp, write_rt, deviated_s4, b_dest_in, inst_adress_s4,
           flush, redirect_pc
  );
  modport slave (
    input  stall, valid_s1, inst_adress_s1, p_s1, hit_s1, b_dest_out,
           is_branch_s4, taken_s4, target_s4,
    output write_rp, write_rt, deviated_s4, b_dest_in, inst_adress_s4,
           flush, redirect_pc
  );
`endif
endinterface

// File: rtl/branch_resolver.sv
// Carries branch-table predictions from fetch to s4, resolves them, updates the table
// and flushes on mispredict. BR_RESOLVER_STATS_EN adds saturating branch/mispredict counters.
module branch_resolver (
  input  logic             clk,
  input  logic             rst,
  branch_resolver_if.slave br
);
  typedef enum logic {IDLE, FLUSH} state_t;

  typedef struct packed {
    logic        valid;
    logic        p;
    logic        hit;
    logic [31:0] dest;
    logic [31:0] pc;
  } stage_t;

  state_t      state_reg, state_next;
  stage_t      stage_reg  [2:4];
  stage_t      stage_next [2:4];
  logic [31:0] redirect_reg, redirect_next;
  logic        act, pt, tgt_mismatch, mispredict;

  assign act          = stage_reg[4].valid & br.is_branch_s4 & ~br.stall;
  assign pt           = stage_reg[4].hit & stage_reg[4].p;
  assign tgt_mismatch = stage_reg[4].dest != br.target_s4;
  assign mispredict   = act & ((br.taken_s4 ^ pt) | (br.taken_s4 & pt & tgt_mismatch));

  assign br.write_rt       = act & br.taken_s4 & (~stage_reg[4].hit | tgt_mismatch);
  assign br.write_rp       = act & (stage_reg[4].hit | br.taken_s4);
  assign br.deviated_s4    = br.taken_s4;
  assign br.b_dest_in      = br.target_s4;
  assign br.inst_adress_s4 = stage_reg[4].pc;
  assign br.redirect_pc    = redirect_reg;

  // Fetch is ignored on the detecting edge and on the FLUSH edge; older stages are squashed.
  always_comb begin
    stage_next[2]       = '{valid: br.valid_s1, p: br.p_s1, hit: br.hit_s1,
                            dest: br.b_dest_out, pc: br.inst_adress_s1};
    stage_next[2].valid = br.valid_s1 & (state_reg == IDLE) & ~mispredict;
  end

  generate
    for (genvar gi = 3; gi <= 4; gi++) begin : g_shift
      always_comb begin
        stage_next[gi]       = stage_reg[gi-1];
        stage_next[gi].valid = stage_reg[gi-1].valid & ~mispredict;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 2; i <= 4; i++) stage_reg[i] <= '0;
    end else if (!br.stall) begin
      for (int i = 2; i <= 4; i++) stage_reg[i] <= stage_next[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      redirect_reg <= '0;
    end else begin
      state_reg    <= state_next;
      redirect_reg <= redirect_next;
    end
  end

  // FLUSH always lasts one cycle, independent of stall.
  always_comb begin
    state_next    = state_reg;
    redirect_next = redirect_reg;
    br.flush      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mispredict) begin
          state_next    = FLUSH;
          redirect_next = br.taken_s4 ? br.target_s4 : stage_reg[4].pc + 32'd4;
        end
      end
      FLUSH: begin
        br.flush   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef BR_RESOLVER_STATS_EN
  logic [15:0] br_count_reg, mp_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_count_reg <= '0;
      mp_count_reg <= '0;
    end else begin
      if (act && br_count_reg != 16'hFFFF) br_count_reg <= br_count_reg + 16'd1;
      if (mispredict && mp_count_reg != 16'hFFFF) mp_count_reg <= mp_count_reg + 16'd1;
    end
  end

  assign br.br_count = br_count_reg;
  assign br.mp_count = mp_count_reg;
`endif
endmodule

// File: tb/tb_branch_resolver.sv
// Random and directed stimulus for branch_resolver, checked cycle by cycle against a
// queue-based model of the in-flight instructions.
module tb_branch_resolver;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_resolver_if bif ();
  branch_resolver dut (.clk(clk), .rst(rst), .br(bif));

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit        valid;
    bit        p;
    bit        hit;
    bit [31:0] dest;
    bit [31:0] pc;
  } rec_t;

  // Instructions in flight behind fetch: index 0 is the youngest, index 2 sits in s4.
  rec_t        pipe [$];
  bit          m_flush;
  bit [31:0]   m_redir;
  int unsigned m_br, m_mp;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    rec_t empty;
    empty = '{0, 0, 0, 0, 0};
    pipe.delete();
    repeat (3) pipe.push_back(empty);
    m_flush = 0;
    m_redir = 0;
    m_br    = 0;
    m_mp    = 0;
  endtask

  task automatic step(bit r, bit st, bit v1, bit [31:0] pc1, bit p1, bit h1, bit [31:0] d1,
                      bit isb, bit tk, bit [31:0] tg);
    rec_t s4, nr;
    bit   act, pt, mm, mis, e_rp, e_rt, was_flush;
    @(posedge clk);
    #1;
    rst                = r;
    bif.stall          = st;
    bif.valid_s1       = v1;
    bif.inst_adress_s1 = pc1;
    bif.p_s1           = p1;
    bif.hit_s1         = h1;
    bif.b_dest_out     = d1;
    bif.is_branch_s4   = isb;
    bif.taken_s4       = tk;
    bif.target_s4      = tg;
    if (r) model_reset();
    #3;
    s4   = pipe[2];
    act  = s4.valid & isb & ~st & ~r;
    pt   = s4.hit & s4.p;
    mm   = s4.dest != tg;
    mis  = act & ((tk != pt) || (tk && pt && mm));
    e_rp = act & (s4.hit | tk);
    e_rt = act & tk & (~s4.hit | mm);
    chk("write_rp", bif.write_rp, e_rp);
    chk("write_rt", bif.write_rt, e_rt);
    chk("deviated_s4", bif.deviated_s4, tk);
    chk("b_dest_in", bif.b_dest_in, tg);
    if (s4.valid) chk("inst_adress_s4", bif.inst_adress_s4, s4.pc);
    chk("flush", bif.flush, m_flush);
    if (m_flush || r) chk("redirect_pc", bif.redirect_pc, m_redir);
`ifdef BR_RESOLVER_STATS_EN
    chk("br_count", bif.br_count, m_br);
    chk("mp_count", bif.mp_count, m_mp);
`endif
    $display("t=%0t rst=%0b stall=%0b v1=%0b s4v=%0b br=%0b tk=%0b tg=%h rp=%0b rt=%0b flush=%0b redir=%h",
             $time, r, st, v1, s4.valid, isb, tk, tg, bif.write_rp, bif.write_rt,
             bif.flush, bif.redirect_pc);
    if (!r) begin
      was_flush = m_flush;
      if (mis) m_redir = tk ? tg : s4.pc + 32'd4;
      m_flush = mis;
      if (!st) begin
        nr = '{v1 & ~was_flush & ~mis, p1, h1, d1, pc1};
        pipe.push_front(nr);
        void'(pipe.pop_back());
      end
      if (mis) foreach (pipe[i]) pipe[i].valid = 0;
      if (act && m_br != 32'hFFFF) m_br++;
      if (mis && m_mp != 32'hFFFF) m_mp++;
    end
  endtask

  task automatic feed(bit [31:0] pc, bit p, bit h, bit [31:0] d);
    step(0, 0, 1, pc, p, h, d, 0, 0, 0);
  endtask

  task automatic nop();
    step(0, 0, 1, 32'h1000, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic resolve(bit tk, bit [31:0] tg);
    step(0, 0, 0, 0, 0, 0, 0, 1, tk, tg);
  endtask

  initial begin
    bit [31:0] pc, tg;
    model_reset();
    repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Correctly predicted taken branch: no flush.
    feed(32'h40, 1, 1, 32'h100); nop(); nop();
    resolve(1, 32'h100);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("req035_no_flush", bif.flush, 1'b0);

    // Miss in the table, taken: redirect to the real target.
    feed(32'h80, 0, 0, 32'h0); nop(); nop();
    resolve(1, 32'h200);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("req036_flush", bif.flush, 1'b1);
    chk("req036_redirect", bif.redirect_pc, 32'h200);

    // Predicted taken, actually not taken.
    feed(32'hC0, 1, 1, 32'h500); nop(); nop();
    resolve(0, 32'h500);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("req037_redirect", bif.redirect_pc, 32'hC4);

    // Target mismatch held in s4 by a three-cycle stall.
    feed(32'h600, 1, 1, 32'h300); nop(); nop();
    repeat (3) step(0, 1, 0, 0, 0, 0, 0, 1, 1, 32'h340);
    resolve(1, 32'h340);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("req038_redirect", bif.redirect_pc, 32'h340);

    // Fall-through address wraps to zero.
    feed(32'hFFFF_FFFC, 1, 1, 32'h700); nop(); nop();
    resolve(0, 32'h700);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("req039_redirect", bif.redirect_pc, 32'h0);

    // Reset during FLUSH, then fresh instructions flow through unsquashed.
    feed(32'h900, 0, 0, 32'h0); nop(); nop();
    resolve(1, 32'hA00);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("req040_flush_in_reset", bif.flush, 1'b0);
    feed(32'hB00, 1, 1, 32'hC00); nop(); nop();
    resolve(1, 32'hC00);

    for (int n = 0; n < 400; n++) begin
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      tg = $urandom_range(0, 1) ? pipe[2].dest : ($urandom & 32'hFFFF_FFFC);
      step($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 4) != 0, pc, 1'($urandom), 1'($urandom),
           $urandom & 32'hFFFF_FFFC, $urandom_range(0, 9) < 7, 1'($urandom), tg);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
